// File: rtl/sparse_array_pkg.sv
// Shared types and helpers for the sparse weight-stationary PE array.
package sparse_array_pkg;

  // Sequencer states; exported on the top-level state_dbg port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index widths for the default 4-lane, 4-column configuration.
  localparam int LANE_IDX_W = idx_width(4);
  localparam int COL_IDX_W  = idx_width(4);

  // Accumulator update for widths up to 63 bits.
  // Returns {carry_out, result}; on carry the result either clamps to the
  // all-ones value of 'width' bits or wraps modulo 2^width.
  function automatic logic [64:0] acc_add(input logic [63:0] acc,
                                          input logic [63:0] addend,
                                          input int          width,
                                          input logic        sat);
    logic [64:0] sum;
    logic [64:0] lim;
    logic        carry;
    lim   = (65'd1 << width) - 65'd1;
    sum   = {1'b0, acc} + {1'b0, addend};
    carry = (sum > lim);
    if (carry) sum = sat ? lim : (sum & lim);
    return {carry, sum[63:0]};
  endfunction

endpackage

// File: rtl/sparse_pe_array_ctrl_if.sv
// Command, config, activation and result channels of the sparse PE array.
// Handshakes: a beat transfers on a rising clock edge where valid and ready
// are both 1; the sender holds valid and its payload stable until that edge,
// and ready may be asserted independently of valid.
interface sparse_pe_array_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int LEN_WIDTH  = 8
);
  import sparse_array_pkg::*;

  localparam int COL_W = idx_width(COLS);

  logic                               cmd_valid;
  logic                               cmd_ready;
  logic                               cmd_load;
  logic                               cmd_accum;
  logic                               cmd_dir;
  logic [LEN_WIDTH-1:0]               cmd_len;
  logic                               cfg_valid;
  logic                               cfg_ready;
  logic [COLS*DATA_WIDTH-1:0]         cfg_weight;
  logic [COLS*BLOCK_SIZE-1:0]         cfg_mask;
  logic                               act_valid;
  logic                               act_ready;
  logic [ROWS*BLOCK_SIZE*DATA_WIDTH-1:0] act_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [BLOCK_SIZE*ACC_WIDTH-1:0]    out_data;
  logic [COL_W-1:0]                   out_col;
  logic                               out_last;

  modport master (
    output cmd_valid, cmd_load, cmd_accum, cmd_dir, cmd_len,
    output cfg_valid, cfg_weight, cfg_mask, act_valid, act_data, out_ready,
    input  cmd_ready, cfg_ready, act_ready, out_valid, out_data, out_col, out_last
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_accum, cmd_dir, cmd_len,
    input  cfg_valid, cfg_weight, cfg_mask, act_valid, act_data, out_ready,
    output cmd_ready, cfg_ready, act_ready, out_valid, out_data, out_col, out_last
  );

endinterface

// File: rtl/sparse_pe.sv
// One sparse multiply unit: stationary weight + lane mask, gated lane
// multiplies registered as stage-1 products, and a lane skip count.
module sparse_pe
  import sparse_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_en,
  input  logic [DATA_WIDTH-1:0]              w_in,
  input  logic [BLOCK_SIZE-1:0]              m_in,
  input  logic                               act_en,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   a_in,
  output logic [BLOCK_SIZE*2*DATA_WIDTH-1:0] prod,
  output logic [$clog2(BLOCK_SIZE+1)-1:0]    skip_n
);

  localparam int PW     = 2 * DATA_WIDTH;
  localparam int SKIP_W = $clog2(BLOCK_SIZE + 1);

  logic [DATA_WIDTH-1:0]              w_q;
  logic [BLOCK_SIZE-1:0]              m_q;
  logic [BLOCK_SIZE*2*DATA_WIDTH-1:0] prod_d;

  // Stationary weight and mask, rewritten only by a config beat for this row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      m_q <= '0;
    end else if (load_en) begin
      w_q <= w_in;
      m_q <= m_in;
    end
  end

  // Masked lane products and count of lanes that contribute nothing.
  always_comb begin
    prod_d = '0;
    skip_n = '0;
    for (int l = 0; l < BLOCK_SIZE; l++) begin
      if (m_q[l]) prod_d[l*PW +: PW] = PW'(a_in[l*DATA_WIDTH +: DATA_WIDTH]) * PW'(w_q);
      if (!m_q[l] || (a_in[l*DATA_WIDTH +: DATA_WIDTH] == '0)) skip_n = skip_n + SKIP_W'(1);
    end
  end

  // Stage-1 product register, loaded on each accepted activation beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod <= '0;
    else if (act_en) prod <= prod_d;
  end

endmodule

// File: rtl/sparse_pe_array_ctrl.sv
// ROWS x COLS sparse weight-stationary array with its sequencer: loads
// config rows, streams activation beats through a two-stage multiply /
// column-reduce pipeline into per-lane accumulators, then drains one column
// of accumulators per beat.
module sparse_pe_array_ctrl
  import sparse_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int LEN_WIDTH  = 8,
  parameter int SATURATE   = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  sparse_pe_array_ctrl_if.slave bus,
  output logic                 busy,
  output logic [31:0]          skip_cnt,
  output logic                 ovf,
  output state_t               state_dbg
);

  localparam int PW     = 2 * DATA_WIDTH;
  localparam int SUM_W  = PW + $clog2(ROWS + 1);
  localparam int SKIP_W = $clog2(BLOCK_SIZE + 1);
  localparam int COL_W  = idx_width(COLS);
  localparam int ROW_W  = idx_width(ROWS);

  state_t               state;
  logic                 dir_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [ROW_W-1:0]     row_k;
  logic                 flush_cnt;
  logic                 v1;

  logic [BLOCK_SIZE*PW-1:0]        prod    [ROWS][COLS];
  logic [SKIP_W-1:0]               skip_n  [ROWS][COLS];
  logic [SUM_W-1:0]                col_sum [COLS][BLOCK_SIZE];
  logic [ACC_WIDTH-1:0]            acc     [COLS][BLOCK_SIZE];
  logic [64:0]                     add_res [COLS][BLOCK_SIZE];
  logic [BLOCK_SIZE*ACC_WIDTH-1:0] acc_col [COLS];
  logic [31:0]                     beat_skip;
  logic [32:0]                     skip_sum;

  logic cmd_fire, cfg_fire, act_fire, acc_clear;
  logic [COL_W-1:0] first_col, next_col;
  logic             next_last;

  assign cmd_fire  = (state == S_IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign cfg_fire  = (state == S_LOAD) && bus.cfg_valid && bus.cfg_ready;
  assign act_fire  = (state == S_RUN)  && bus.act_valid && bus.act_ready;
  assign acc_clear = cmd_fire && !bus.cmd_accum;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  assign first_col = dir_q ? COL_W'(COLS - 1) : '0;
  assign next_col  = dir_q ? (bus.out_col - COL_W'(1)) : (bus.out_col + COL_W'(1));
  assign next_last = dir_q ? (next_col == '0) : (next_col == COL_W'(COLS - 1));

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sparse_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
      ) u_pe (
        .clk     (Clk),
        .rst_n   (Rst),
        .load_en (cfg_fire && (row_k == ROW_W'(r))),
        .w_in    (bus.cfg_weight[c*DATA_WIDTH +: DATA_WIDTH]),
        .m_in    (bus.cfg_mask[c*BLOCK_SIZE +: BLOCK_SIZE]),
        .act_en  (act_fire),
        .a_in    (bus.act_data[r*BLOCK_SIZE*DATA_WIDTH +: BLOCK_SIZE*DATA_WIDTH]),
        .prod    (prod[r][c]),
        .skip_n  (skip_n[r][c])
      );
    end
  end

  // Column reduction over rows, accumulator update and drain-side packing.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      acc_col[c] = '0;
      for (int l = 0; l < BLOCK_SIZE; l++) begin
        col_sum[c][l] = '0;
        for (int r = 0; r < ROWS; r++)
          col_sum[c][l] = col_sum[c][l] + SUM_W'(prod[r][c][l*PW +: PW]);
        add_res[c][l] = acc_add(64'(acc[c][l]), 64'(col_sum[c][l]), ACC_WIDTH, SATURATE != 0);
        acc_col[c][l*ACC_WIDTH +: ACC_WIDTH] = acc[c][l];
      end
    end
  end

  // Skipped lane-products contributed by the beat being accepted.
  always_comb begin
    beat_skip = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        beat_skip = beat_skip + 32'(skip_n[r][c]);
    skip_sum = {1'b0, skip_cnt} + {1'b0, beat_skip};
  end

  // Stage-2 accumulate, stage valid, skip counter and sticky overflow.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      v1       <= 1'b0;
      skip_cnt <= '0;
      ovf      <= 1'b0;
      for (int c = 0; c < COLS; c++)
        for (int l = 0; l < BLOCK_SIZE; l++) acc[c][l] <= '0;
    end else if (acc_clear) begin
      v1       <= 1'b0;
      skip_cnt <= '0;
      ovf      <= 1'b0;
      for (int c = 0; c < COLS; c++)
        for (int l = 0; l < BLOCK_SIZE; l++) acc[c][l] <= '0;
    end else begin
      v1 <= act_fire;
      if (act_fire) skip_cnt <= skip_sum[32] ? '1 : skip_sum[31:0];
      if (v1) begin
        for (int c = 0; c < COLS; c++)
          for (int l = 0; l < BLOCK_SIZE; l++) begin
            acc[c][l] <= add_res[c][l][ACC_WIDTH-1:0];
            if (add_res[c][l][64]) ovf <= 1'b1;
          end
      end
    end
  end

  // Sequencer with registered ready/valid and drain outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state         <= S_IDLE;
      dir_q         <= 1'b0;
      len_q         <= '0;
      beat_cnt      <= '0;
      row_k         <= '0;
      flush_cnt     <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.cfg_ready <= 1'b0;
      bus.act_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_col   <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            bus.cmd_ready <= 1'b0;
            dir_q         <= bus.cmd_dir;
            len_q         <= bus.cmd_len;
            row_k         <= '0;
            beat_cnt      <= '0;
            flush_cnt     <= 1'b0;
            if (bus.cmd_load) begin
              state         <= S_LOAD;
              bus.cfg_ready <= 1'b1;
            end else if (bus.cmd_len == '0) begin
              state <= S_FLUSH;
            end else begin
              state         <= S_RUN;
              bus.act_ready <= 1'b1;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_fire) begin
            if (row_k == ROW_W'(ROWS - 1)) begin
              bus.cfg_ready <= 1'b0;
              if (len_q == '0) begin
                state <= S_FLUSH;
              end else begin
                state         <= S_RUN;
                bus.act_ready <= 1'b1;
              end
            end else begin
              row_k <= row_k + ROW_W'(1);
            end
          end
        end
        S_RUN: begin
          if (act_fire) begin
            if (beat_cnt == len_q - LEN_WIDTH'(1)) begin
              state         <= S_FLUSH;
              bus.act_ready <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt) begin
            state         <= S_DRAIN;
            bus.out_valid <= 1'b1;
            bus.out_col   <= first_col;
            bus.out_data  <= acc_col[first_col];
            bus.out_last  <= (COLS == 1);
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.out_valid && bus.out_ready) begin
            if (bus.out_last) begin
              state         <= S_IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.cmd_ready <= 1'b1;
            end else begin
              bus.out_col  <= next_col;
              bus.out_data <= acc_col[next_col];
              bus.out_last <= next_last;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
